if_prefetch: RTL
================

IF_PREFETCH -- requirements
Module: if_prefetch

Interface
- REQ-001: Parameter XLEN, default 32, datapath and PC width in bits.
- REQ-002: Parameter AW, default 10, instruction-memory word-address width.
- REQ-003: Parameter DEPTH, default 4, prefetch buffer entries; power of two, >= 2.
- REQ-004: Parameter RESET_PC, default 0, byte address fetched first after reset.
- REQ-005: clk  in  1  single clock; all state updates on its rising edge.
- REQ-006: rst  in  1  reset, synchronous and active-high.
- REQ-007: cond  in  1  redirect request; when 1, condNPC replaces the fetch stream.
- REQ-008: condNPC  in  XLEN  redirect target byte address.
- REQ-009: stall  in  1  downstream hold; when 1, the presented instruction is not consumed.
- REQ-010: imem_en  out  1  fetch request to the synchronous instruction memory.
- REQ-011: imem_addr  out  AW  word address, equal to PC[AW+1:2].
- REQ-012: imem_rdata  in  XLEN  instruction word, valid the cycle after imem_en=1.
- REQ-013: valid  out  1  NPC/IRo hold a live instruction.
- REQ-014: NPC  out  XLEN  fetch address of presented instruction plus 4.
- REQ-015: IRo  out  XLEN  presented instruction word.

Function
- REQ-016: PC register advances by 4 on each issued fetch; arithmetic is modulo 2^XLEN, so 0xFFFF_FFFC wraps to 0.
- REQ-017: Issue (imem_en=1) when count + inflight < DEPTH and cond=0; inflight is a 1-bit flag set on issue and cleared on response.
- REQ-018: Response is written to the buffer tail as {fetchPC+4, imem_rdata} on the edge ending the response cycle, unless discarded.
- REQ-019: valid = buffer not empty; NPC/IRo show the head entry; both are 0 when valid=0.
- REQ-020: Pop at the edge when valid=1 and stall=0; stall=1 holds the head stable indefinitely.
- REQ-021: Simultaneous push and pop leave the count unchanged; read/write pointers wrap modulo DEPTH.
- REQ-022: Full buffer: no issue, no push lost; with stall=0 and no redirect, sustained throughput is one instruction per cycle.
- REQ-023: cond=1 at an edge: buffer flushed, in-flight response discarded, PC <= condNPC; valid=0 the next cycle.
- REQ-024: Redirect latency: imem_en for condNPC in the cycle after the sampling edge; valid=1 with NPC=condNPC+4 after the second edge following the sampling edge.
- REQ-025: Redirect has priority over stall, pop, push and issue in the same cycle.
- REQ-026: Consecutive cond=1 cycles: the last sampled condNPC wins; no fetch is issued while cond=1.
- REQ-027: condNPC[1:0] is ignored for addressing; NPC carries the full value plus 4.

Reset
- REQ-028: rst=1 at an edge: PC <= RESET_PC, buffer empty, inflight=0, valid=0, NPC=0, IRo=0, imem_en=0 that cycle.
- REQ-029: Reset overrides cond, stall and any in-flight response, including mid-burst.
- REQ-030: First imem_en with imem_addr=RESET_PC[AW+1:2] occurs in the first cycle with rst=0.

Structure
- REQ-031: Package if_pkg holds the XLEN default, the RESET_PC default and the buffer entry type {npc, ir}.
- REQ-032: Buffer is sub-module if_fifo: synchronous FIFO with push, pop, flush, count, full and empty; flush has priority over push.
- REQ-033: PC, issue and discard logic live in if_prefetch; no combinational path from imem_rdata to valid.

Verification (bench memory: word i = 0x1000_0000 + i)
- REQ-034: Release reset, stall=0, cond=0 -> valid after the 2nd edge; IRo sequence 0x1000_0000, _0001, _0002..., NPC 4, 8, 12...; one per cycle.
- REQ-035: stall=1 for 10 cycles after 2 pops -> IRo held at 0x1000_0002; imem_en drops once count+inflight=4; resumes in order with no loss or duplication.
- REQ-036: cond=1 with condNPC=0x40 while full and stalled -> valid=0 next cycle; then IRo 0x1000_0010, NPC 0x44.
- REQ-037: cond=1 on 2 consecutive cycles, condNPC 0x80 then 0xC0 -> first valid IRo is 0x1000_0030; nothing from 0x80 appears.
- REQ-038: rst=1 for 1 cycle mid-stream while a fetch is in flight -> valid=0, NPC=0, IRo=0; restart at RESET_PC; stale word never presented.
- REQ-039: condNPC=0xFFFF_FFFC, AW=30 -> NPC 0x0000_0000, then fetch wraps to address 0.

Source files
------------

// File: rtl/if_pkg.sv
// Shared definitions for the instruction prefetch slice.
//   XLEN_DEF     : default datapath / PC width
//   RESET_PC_DEF : default byte address fetched first after reset
//   if_entry_t   : prefetch buffer entry {npc, ir} at the default width
package if_pkg;

    localparam int XLEN_DEF = 32;
    localparam longint unsigned RESET_PC_DEF = 64'h0;

    typedef struct packed {
        logic [XLEN_DEF-1:0] npc;
        logic [XLEN_DEF-1:0] ir;
    } if_entry_t;

endpackage

// File: rtl/if_prefetch_if.sv
// Instruction-memory request/response bundle.
//   imem_en    : fetch request (master -> memory)
//   imem_addr  : word address (master -> memory)
//   imem_rdata : instruction word, valid the cycle after imem_en (memory -> master)
interface if_prefetch_if #(
    parameter int XLEN = if_pkg::XLEN_DEF,
    parameter int AW   = 10
);
    logic            imem_en;
    logic [AW-1:0]   imem_addr;
    logic [XLEN-1:0] imem_rdata;

    modport master (output imem_en, output imem_addr, input imem_rdata);
    modport slave  (input imem_en, input imem_addr, output imem_rdata);
endinterface

// File: rtl/if_fifo.sv
// Synchronous FIFO holding prefetched entries.
//   clk, rst     : clock, synchronous active-high reset
//   flush        : empties the FIFO; wins over push and pop
//   push, wdata  : write one entry at the tail
//   pop          : drop the head entry
//   rdata        : head entry (meaningful when empty=0)
//   count        : number of stored entries
//   full, empty  : occupancy flags
module if_fifo
    import if_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = if_entry_t,
    localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW      = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  entry_t        wdata,
    output entry_t        rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop_en;
    logic          push_en;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_en  = pop && !empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign push_en = push && (!full || pop_en);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop_en)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push_en) - CW'(pop_en);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en && !flush && !rst) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch unit: keeps a synchronous instruction memory busy and
// buffers fetched words so one instruction per cycle can be presented downstream.
//   clk, rst : clock, synchronous active-high reset
//   cond     : redirect request, condNPC replaces the fetch stream
//   condNPC  : redirect target byte address
//   stall    : downstream hold of the presented instruction
//   imem     : instruction-memory request/response (master side)
//   valid    : NPC/IRo hold a live instruction
//   NPC      : fetch address of the presented instruction plus 4
//   IRo      : presented instruction word
module if_prefetch
    import if_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              AW       = 10,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cond,
    input  logic [XLEN-1:0]  condNPC,
    input  logic             stall,
    if_prefetch_if.master    imem,
    output logic             valid,
    output logic [XLEN-1:0]  NPC,
    output logic [XLEN-1:0]  IRo
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] npc;
        logic [XLEN-1:0] ir;
    } entry_t;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] fetch_pc;
    logic            inflight;
    logic            issue;
    logic            push;
    logic            pop;
    logic            flush;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    entry_t          wdata;
    entry_t          head;

    // Reserve a buffer slot for every outstanding fetch so a response is never dropped.
    assign issue = !rst && !cond && !full && ((int'(count) + int'(inflight)) < DEPTH);
    // A redirect discards the response that arrives in the redirect cycle.
    assign push  = inflight && !cond && !rst;
    assign flush = cond;
    assign pop   = !stall;

    assign wdata.npc = fetch_pc + XLEN'(4);
    assign wdata.ir  = imem.imem_rdata;

    assign imem.imem_en   = issue;
    assign imem.imem_addr = pc[AW+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
        end else if (cond) begin
            pc       <= condNPC;
            inflight <= 1'b0;
        end else begin
            if (issue) begin
                pc       <= pc + XLEN'(4);
                fetch_pc <= pc;
            end
            // At most one fetch outstanding: a response clears the flag, a new issue sets it.
            inflight <= issue;
        end
    end

    if_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign valid = !empty;
    assign NPC   = empty ? '0 : head.npc;
    assign IRo   = empty ? '0 : head.ir;

endmodule
